// File: rtl/frame_aligner_pkg.sv
// Shared types and sizing helpers for the frame aligner and the downstream
// sliding window.
//   frame_state_e : admission FSM states
//   out_dim       : valid-window count along one axis (in - win + 1)
//   idx_width     : bits needed to index 0..n-1 (at least 1)
package frame_aligner_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2
  } frame_state_e;

  function automatic int out_dim(input int in_dim, input int win_dim);
    return in_dim - win_dim + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_aligner_position_counter.sv
// frame_position_counter: raster (row,col) position over a Height x Width
// frame. Advances one position per enabled cycle; col wraps Width-1 -> 0 and
// bumps row, row wraps Height-1 -> 0.
// Ports:
//   clock_i     in   clock, posedge
//   reset_i     in   async active-low reset
//   en_i        in   advance one position
//   row_o       out  current row
//   col_o       out  current column
//   is_first_o  out  position is (0,0)
//   is_last_o   out  position is (Height-1,Width-1)
module frame_position_counter
  import frame_aligner_pkg::*;
#(
  parameter int Height = 4,
  parameter int Width  = 5,
  localparam int RowW  = idx_width(Height),
  localparam int ColW  = idx_width(Width)
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            en_i,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic            is_first_o,
  output logic            is_last_o
);

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic            row_last, col_last;

  assign row_last = (row_q == RowW'(Height - 1));
  assign col_last = (col_q == ColW'(Width - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign is_first_o = (row_q == '0) && (col_q == '0);
  assign is_last_o  = row_last && col_last;

endmodule

// File: rtl/frame_aligner.sv
// frame_aligner: admits pixels to the sliding window only as whole,
// SOF-aligned InHeight x InWidth frames. Pixels before a SOF are dropped,
// a frame cut short by an early SOF is padded with PadValue, and surplus
// pixels past the end of a frame are dropped. Windows leaving the sliding
// window are tagged SOF/EOL/EOF by watching its output handshake.
// Ports:
//   clock_i, reset_i           clock (posedge), async active-low reset
//   slave_*                    upstream pixel stream (valid/ready/data/sof)
//   master_*                   pixel stream toward the sliding window
//   win_valid_i, win_ready_i   observed sliding-window output handshake
//   win_sof_o/eol_o/eof_o      tags for the window currently presented
//   frame_done_o               1-cycle pulse after the last beat of a frame
//   pad_count_o, drop_count_o  saturating pad/drop statistics
//
// state  | meaning
// SYNC   | hunting for SOF; non-SOF pixels are accepted and dropped
// STREAM | zero-latency pass-through of an aligned frame
// PAD    | filling the rest of a truncated frame; the early SOF is held
module frame_aligner
  import frame_aligner_pkg::*;
#(
  parameter int                   InHeight     = 600,
  parameter int                   InWidth      = 800,
  parameter int                   WindowHeight = 3,
  parameter int                   WindowWidth  = 3,
  parameter int                   DataWidth    = 8,
  parameter logic [DataWidth-1:0] PadValue     = '0,
  parameter int                   StatWidth    = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 slave_valid_i,
  output logic                 slave_ready_o,
  input  logic [DataWidth-1:0] slave_data_i,
  input  logic                 slave_sof_i,
  output logic                 master_valid_o,
  input  logic                 master_ready_i,
  output logic [DataWidth-1:0] master_data_o,
  input  logic                 win_valid_i,
  input  logic                 win_ready_i,
  output logic                 win_sof_o,
  output logic                 win_eol_o,
  output logic                 win_eof_o,
  output logic                 frame_done_o,
  output logic [StatWidth-1:0] pad_count_o,
  output logic [StatWidth-1:0] drop_count_o
);

  localparam int OutH    = out_dim(InHeight, WindowHeight);
  localparam int OutW    = out_dim(InWidth, WindowWidth);
  localparam int InRowW  = idx_width(InHeight);
  localparam int InColW  = idx_width(InWidth);
  localparam int WinRowW = idx_width(OutH);
  localparam int WinColW = idx_width(OutW);

  frame_state_e   state_q, state_d;
  logic           sready_c, mvalid_c;
  logic           drop_inc, pad_inc;
  logic           beat;
  logic           frame_done_q;
  logic [StatWidth-1:0] pad_q, pad_d, drop_q, drop_d;

  logic [InRowW-1:0]  in_row;
  logic [InColW-1:0]  in_col;
  logic               in_first, in_last;
  logic [WinRowW-1:0] w_row;
  logic [WinColW-1:0] w_col;
  logic               w_first, w_last;
  logic               unused_pos;

  // Gate the handshake with reset so nothing is offered or accepted while
  // reset is held, even though SYNC would otherwise assert ready.
  assign slave_ready_o  = reset_i & sready_c;
  assign master_valid_o = reset_i & mvalid_c;
  assign beat           = master_valid_o & master_ready_i;

  frame_position_counter #(
    .Height (InHeight),
    .Width  (InWidth)
  ) u_in_pos (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .en_i       (beat),
    .row_o      (in_row),
    .col_o      (in_col),
    .is_first_o (in_first),
    .is_last_o  (in_last)
  );

  frame_position_counter #(
    .Height (OutH),
    .Width  (OutW)
  ) u_win_pos (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .en_i       (win_valid_i & win_ready_i),
    .row_o      (w_row),
    .col_o      (w_col),
    .is_first_o (w_first),
    .is_last_o  (w_last)
  );

  assign unused_pos = ^{in_row, in_col, w_last};

  always_comb begin
    state_d       = state_q;
    sready_c      = 1'b0;
    mvalid_c      = 1'b0;
    master_data_o = slave_data_i;
    drop_inc      = 1'b0;
    pad_inc       = 1'b0;
    unique case (state_q)
      SYNC: begin
        if (slave_sof_i) begin
          mvalid_c = slave_valid_i;
          sready_c = master_ready_i;
          if (slave_valid_i && master_ready_i) begin
            // A 1x1 frame completes on its SOF beat.
            state_d = in_last ? SYNC : STREAM;
          end
        end else begin
          sready_c = 1'b1;
          drop_inc = slave_valid_i;
        end
      end
      STREAM: begin
        if (slave_valid_i && slave_sof_i && !in_first) begin
          // Early SOF: hold it upstream and finish the frame with padding.
          state_d = PAD;
        end else if (slave_valid_i && !slave_sof_i && in_first) begin
          // Frame already complete; this pixel is surplus.
          sready_c = 1'b1;
          drop_inc = 1'b1;
          state_d  = SYNC;
        end else begin
          mvalid_c = slave_valid_i;
          sready_c = master_ready_i;
        end
      end
      PAD: begin
        mvalid_c      = 1'b1;
        master_data_o = PadValue;
        pad_inc       = master_ready_i;
        if (master_ready_i && in_last) state_d = SYNC;
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    pad_d  = pad_q;
    drop_d = drop_q;
    if (reset_i && pad_inc && (pad_q != '1))   pad_d  = pad_q + StatWidth'(1);
    if (reset_i && drop_inc && (drop_q != '1)) drop_d = drop_q + StatWidth'(1);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= SYNC;
      frame_done_q <= 1'b0;
      pad_q        <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= beat & in_last;
      pad_q        <= pad_d;
      drop_q       <= drop_d;
    end
  end

  assign frame_done_o = frame_done_q;
  assign pad_count_o  = pad_q;
  assign drop_count_o = drop_q;

  assign win_sof_o = w_first;
  assign win_eol_o = (w_col == WinColW'(OutW - 1));
  assign win_eof_o = win_eol_o && (w_row == WinRowW'(OutH - 1));

endmodule
